bram_dump: RTL
==============

BRAM_DUMP -- requirements
Module: bram_dump

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, byte-address width of the debug read port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  ADDR_WIDTH  byte address of first word; bits [1:0] ignored; latched on accepted start.
REQ-006 SHALL have port word_count  input  ADDR_WIDTH  number of 32-bit words to dump; latched on accepted start.
REQ-007 SHALL have port dbg_addr  output  ADDR_WIDTH  drives the BRAM debug read address.
REQ-008 SHALL have port dbg_data  input  32  BRAM debug read data.
REQ-009 SHALL have port tx_data  output  8  outgoing byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  sink accepts byte when tx_valid and tx_ready are both high on a rising edge.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE; usable as the CPU pc stall request.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of dump.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, LOAD, SEND, CSUM, DONE.
REQ-015 IDLE: start=1 with word_count!=0 -> ADDR; start=1 with word_count=0 -> DONE; otherwise stay.
REQ-016 ADDR: dbg_addr = current word address (low 2 bits zero); next state LOAD.
REQ-017 LOAD: dbg_data SHALL be captured into a 32-bit word register; byte index cleared to 0; next state SEND. The one-cycle address-to-capture gap covers both combinational and registered BRAM read ports.
REQ-018 SEND: tx_valid=1, tx_data=word[8*idx+7:8*idx], little-endian, byte 0 first.
REQ-019 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-020 On handshake with idx<3: idx increments.
REQ-021 On handshake with idx=3 and words remaining >1: address += 4 and -> ADDR.
REQ-022 On handshake with idx=3 and last word: -> CSUM if enabled, else -> DONE.
REQ-023 Address increment SHALL wrap modulo 2^ADDR_WIDTH, so 0x3FC is followed by 0x000.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 start asserted outside IDLE SHALL be ignored, with no effect on latched operands.
REQ-026 Latency: the first tx_valid SHALL rise on the third rising edge after the edge sampling start.
REQ-027 Minimum word period with tx_ready held high SHALL be 6 cycles: ADDR, LOAD, 4x SEND.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, dbg_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, and clear the internal word, count, idx and checksum registers.
REQ-029 Reset mid-dump SHALL abandon the dump with no done pulse; the first start after rst returns high SHALL begin a fresh dump.

Configuration
REQ-030 With macro BRAM_DUMP_CHECKSUM_EN defined: a running XOR of all emitted data bytes (cleared on accepted start) SHALL be sent as one extra byte in CSUM under the same valid/ready rules, then -> DONE.
REQ-031 Without BRAM_DUMP_CHECKSUM_EN: the CSUM state and checksum register are absent, and the last data byte goes directly to DONE.

Verification
REQ-032 Memory 0x4=00000000, 0x8=00000001, 0xC=00000001; base 0x4, count 3, tx_ready=1 -> bytes 00 00 00 00 01 00 00 00 01 00 00 00 (plus 00 if checksum enabled), then one done pulse.
REQ-033 Word 0x11223344 at 0x0, tx_ready toggling 1/0 -> bytes 44 33 22 11 (checksum 44); tx_data constant during each stall.
REQ-034 word_count=0 -> tx_valid never asserted; done high for exactly one cycle; busy high for one cycle.
REQ-035 base 0x3FC, count 2 -> dbg_addr 0x3FC, then 0x000; 8 bytes emitted.
REQ-036 rst=0 during SEND idx=2 -> tx_valid=0 and busy=0 without waiting for a clock edge, no done pulse; new start with base 0x8, count 1 -> 01 00 00 00.
REQ-037 start pulsed with base 0x0 during an active dump -> ignored; output stream identical to the undisturbed dump.

Source files
------------

// File: rtl/bram_dump.sv
// bram_dump: streams a block of 32-bit words from a BRAM debug read port out
// as little-endian bytes over a valid/ready byte sink, stalling the CPU via busy.
// Optional feature: define BRAM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module bram_dump #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

`ifdef BRAM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StAddr, StLoad, StSend, StCsum, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StAddr, StLoad, StSend, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            idx_q, idx_d;
`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  // Address is held between words; a registered BRAM port sees it during ADDR.
  assign dbg_addr = addr_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef BRAM_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef BRAM_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state logic and byte-stream outputs.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    word_d   = word_q;
    idx_d    = idx_q;
`ifdef BRAM_DUMP_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = {base_addr[ADDR_WIDTH-1:2], 2'b00};
          count_d = word_count;
`ifdef BRAM_DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = (word_count != '0) ? StAddr : StDone;
        end
      end
      StAddr: state_d = StLoad;
      StLoad: begin
        // One cycle after ADDR covers combinational and registered read ports.
        word_d  = dbg_data;
        idx_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        tx_valid = 1'b1;
        tx_data  = word_q[{idx_q, 3'b000} +: 8];
        if (tx_ready) begin
`ifdef BRAM_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ tx_data;
`endif
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (count_q > ADDR_WIDTH'(1)) begin
            count_d = count_q - ADDR_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(4);  // wraps at the top of the port
            state_d = StAddr;
          end else begin
`ifdef BRAM_DUMP_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef BRAM_DUMP_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

endmodule
